sub32_seq: RTL and testbench

SUB32_SEQ -- requirements
Module: sub32_seq

---
 rtl/sub32_seq_if.sv | 24 ++
 rtl/sub32_seq.sv | 116 +++++++++++
 tb/tb_sub32_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sub32_seq_if.sv
// Operand/result handshake bundle for the byte-serial 32-bit subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface sub32_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [32:1] A;
   logic [32:1] B;
   logic        b0;
   logic        out_valid;
   logic        out_ready;
   logic [32:1] D;
   logic        b32;
   logic        ovf;

   modport master (
      output in_valid, A, B, b0, out_ready,
      input  in_ready, out_valid, D, b32, ovf
   );

   modport slave (
      input  in_valid, A, B, b0, out_ready,
      output in_ready, out_valid, D, b32, ovf
   );
endinterface

// File: rtl/sub32_seq.sv
// Byte-serial 32-bit subtractor: D = A - B - b0, one 8-bit slice per cycle
// with a registered borrow chain; result published only on entry to DONE.
module sub32_seq (
   input logic        clk,
   input logic        rst_n,
   sub32_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_cnt;
   logic [32:1] r_a;
   logic [32:1] r_b;
   logic        r_bor;
   logic [24:1] r_res;
   logic [32:1] r_d;
   logic        r_b32;
   logic        r_ovf;

   logic [7:0]  w_a_sl;
   logic [7:0]  w_b_sl;
   logic [8:0]  w_diff;
   logic        w_bout;
   logic        w_ovf;

   // Bit 8 of the 9-bit result is the slice borrow-out.
   function automatic logic [8:0] sub_slice(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       bin);
      sub_slice = {1'b0, a} - {1'b0, b} - {8'd0, bin};
   endfunction

   always_comb begin
      w_a_sl = r_a[8:1];
      w_b_sl = r_b[8:1];
      case (r_cnt)
         2'd0: begin w_a_sl = r_a[8:1];   w_b_sl = r_b[8:1];   end
         2'd1: begin w_a_sl = r_a[16:9];  w_b_sl = r_b[16:9];  end
         2'd2: begin w_a_sl = r_a[24:17]; w_b_sl = r_b[24:17]; end
         default: begin w_a_sl = r_a[32:25]; w_b_sl = r_b[32:25]; end
      endcase
   end

   assign w_diff = sub_slice(w_a_sl, w_b_sl, r_bor);
   assign w_bout = w_diff[8];
   // Only meaningful on the top slice, where w_diff[7] is the sign of D.
   assign w_ovf  = (r_a[32] != r_b[32]) && (w_diff[7] != r_a[32]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_next = CALC;
         CALC:    if (r_cnt == 2'd3) w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The top slice goes straight to D, so the staging register holds 24 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 2'd0;
         r_a   <= '0;
         r_b   <= '0;
         r_bor <= 1'b0;
         r_res <= '0;
         r_d   <= '0;
         r_b32 <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a   <= bus.A;
                  r_b   <= bus.B;
                  r_bor <= bus.b0;
                  r_cnt <= 2'd0;
               end
            end
            CALC: begin
               r_bor <= w_bout;
               case (r_cnt)
                  2'd0: r_res[8:1]   <= w_diff[7:0];
                  2'd1: r_res[16:9]  <= w_diff[7:0];
                  2'd2: r_res[24:17] <= w_diff[7:0];
                  default: begin
                     r_d   <= {w_diff[7:0], r_res};
                     r_b32 <= w_bout;
                     r_ovf <= w_ovf;
                  end
               endcase
               if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.D         = r_d;
   assign bus.b32       = r_b32;
   assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sub32_seq.sv
// Scoreboard bench for sub32_seq: stimulus pushes expected results, a
// negedge monitor pops and compares on every output handshake.
module tb_sub32_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sub32_seq_if bus ();

   sub32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        b;
      logic        o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit   rnd_ready  = 1'b0;
   logic ready_hold = 1'b1;
   logic ready_rand = 1'b1;
   assign bus.out_ready = rnd_ready ? ready_rand : ready_hold;

   always @(posedge clk) begin
      #1 ready_rand = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c);
      logic [32:0] t;
      exp_t e;
      t   = {1'b0, a} - {1'b0, b} - {32'd0, c};
      e.d = t[31:0];
      e.b = t[32];
      e.o = (a[31] != b[31]) && (t[31] != a[31]);
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got D=%h expected no result", bus.D);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("D",   bus.D,              e.d);
            chk("b32", {31'd0, bus.b32},   {31'd0, e.b});
            chk("ovf", {31'd0, bus.ovf},   {31'd0, e.o});
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] ed, input logic eb, input logic eo);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=0 expected 1");
      end else begin
         bus.A = a; bus.B = b; bus.b0 = c; bus.in_valid = 1'b1;
         e.d = ed; e.b = eb; e.o = eo;
         sb.push_back(e);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.A = ~a; bus.B = ~b; bus.b0 = ~c;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sb.size(), 32'd0);
      // Let the consuming edge land before moving on.
      @(posedge clk);
      #1;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      int   n;
      exp_t e;
      exp_t m;
      logic [31:0] ra, rb;
      logic        rc;

      bus.in_valid = 1'b0;
      bus.A = '0; bus.B = '0; bus.b0 = 1'b0;
      ready_hold = 1'b1;

      #2;
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_D",         bus.D,                  32'd0);
      chk("rst_b32",       {31'd0, bus.b32},       32'd0);
      chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic case with latency measurement.
      @(negedge clk);
      bus.A = 32'h0000_0005; bus.B = 32'h0000_0003; bus.b0 = 1'b0; bus.in_valid = 1'b1;
      e.d = 32'h0000_0002; e.b = 1'b0; e.o = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0; bus.A = 32'hDEAD_BEEF; bus.B = 32'h1234_5678; bus.b0 = 1'b1;
      chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.out_valid && lat < 20);
      chk("latency", 32'(lat), 32'd4);
      wait_drain();

      issue(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
      issue(32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0);
      issue(32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0);
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      wait_drain();

      // Backpressure with input toggling while the result is held.
      ready_hold = 1'b0;
      issue(32'h1234_5678, 32'h0000_00FF, 1'b0, 32'h1234_5579, 1'b0, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 50);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = i[0];
         bus.A = $urandom; bus.B = $urandom; bus.b0 = i[1];
         @(negedge clk);
         chk("bp_D",        bus.D,                  32'h1234_5579);
         chk("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
         chk("bp_hold",     {31'd0, bus.out_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ready_hold = 1'b1;
      @(posedge clk);
      #1;
      chk("next_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.A = 32'h7FFF_FFFF; bus.B = 32'hFFFF_FFFF; bus.b0 = 1'b0; bus.in_valid = 1'b1;
      e.d = 32'h8000_0000; e.b = 1'b1; e.o = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("next_accept", {31'd0, bus.in_ready}, 32'd0);
      wait_drain();

      // Reset during the second CALC cycle aborts the operation.
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.A = 32'h0000_0001; bus.B = 32'h0000_0001; bus.b0 = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_D",         bus.D,                  32'd0);
      chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("abort_b32",       {31'd0, bus.b32},       32'd0);
      chk("abort_ovf",       {31'd0, bus.ovf},       32'd0);
      bus.A = 32'hFFFF_FFFF; bus.B = 32'h0000_0001; bus.b0 = 1'b0; bus.in_valid = 1'b1;
      e.d = 32'hFFFF_FFFE; e.b = 1'b0; e.o = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("first_accept", {31'd0, bus.in_ready}, 32'd0);
      wait_drain();

      // Random operands with random consumer stalls.
      rnd_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         m  = model(ra, rb, rc);
         issue(ra, rb, rc, m.d, m.b, m.o);
      end
      wait_drain();
      rnd_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
